// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request bus between memory stage and data-memory responder
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with wait states and error flagging
// Optional macro DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count,
  output logic [15:0]     err_count
`endif
);
  localparam int               CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               NO_WAIT  = (WAIT_STATES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              err_q;
  logic [31:0]       mem [2**ADDR_W];

  logic              acc_err;
  logic              enter_resp;
  logic              sel_we;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_idx;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_be;

  assign acc_err = (bus.addr[1:0] != 2'b00) || (bus.addr[31:ADDR_W+2] != '0);

  // With zero wait states the accept edge is also the RESP entry edge, so the
  // access must use the live bus fields instead of the latched copies.
  always_comb begin
    enter_resp = 1'b0;
    sel_we     = we_q;
    sel_err    = err_q;
    sel_idx    = idx_q;
    sel_wdata  = wdata_q;
    sel_be     = be_q;
    if (state == S_IDLE) begin
      enter_resp = bus.req && NO_WAIT;
      sel_we     = bus.we;
      sel_err    = acc_err;
      sel_idx    = bus.addr[ADDR_W+1:2];
      sel_wdata  = bus.wdata;
      sel_be     = bus.be;
    end else if (state == S_WAIT) begin
      enter_resp = (cnt == CNT_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && sel_we && !sel_err) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_be[i]) mem[sel_idx][8*i +: 8] <= sel_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.rdata <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      bus.ack <= enter_resp;
      bus.err <= enter_resp && sel_err;
      if (enter_resp && !sel_we) bus.rdata <= sel_err ? '0 : mem[sel_idx];
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            idx_q    <= bus.addr[ADDR_W+1:2];
            wdata_q  <= bus.wdata;
            be_q     <= bus.be;
            err_q    <= acc_err;
            cnt      <= CNT_LOAD;
            bus.busy <= 1'b1;
            state    <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_RESP;
        end
        S_RESP: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (state == S_RESP) begin
      if (err_q) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (we_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at 2 and 0 wait states
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if b0 ();
  dmem_responder_if b2 ();

  logic        sel = 1'b1;
  logic        req_d = 1'b0;
  logic        we_d = 1'b0;
  logic [31:0] addr_d = '0;
  logic [31:0] wdata_d = '0;
  logic [3:0]  be_d = '0;

  assign b2.req   = req_d && sel;
  assign b2.we    = we_d;
  assign b2.addr  = addr_d;
  assign b2.wdata = wdata_d;
  assign b2.be    = be_d;
  assign b0.req   = req_d && !sel;
  assign b0.we    = we_d;
  assign b0.addr  = addr_d;
  assign b0.wdata = wdata_d;
  assign b0.be    = be_d;

  logic        obs_ack, obs_err, obs_busy;
  logic [31:0] obs_rdata;
  assign obs_ack   = sel ? b2.ack   : b0.ack;
  assign obs_err   = sel ? b2.err   : b0.err;
  assign obs_busy  = sel ? b2.busy  : b0.busy;
  assign obs_rdata = sel ? b2.rdata : b0.rdata;

`ifdef DMEM_STATS_EN
  logic [15:0] rd0, wr0, er0, rd2, wr2, er2;
  dmem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .rd_count(rd2), .wr_count(wr2), .err_count(er2));
  dmem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .rd_count(rd0), .wr_count(wr0), .err_count(er0));
`else
  dmem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  dmem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
`endif

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];
  logic [31:0] last_rd [2];
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Model predicts the response, then the transaction is driven and the ack popped.
  task automatic do_txn(input int inst, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    int   lat;
    bit   seen;
    e.err = (a[1:0] != 2'b00) || (a[31:10] != '0);
    e.lat = (inst == 1) ? 3 : 1;
    if (!w) begin
      e.rdata = e.err ? 32'h0 : model[inst][a[9:2]];
      last_rd[inst] = e.rdata;
    end else begin
      e.rdata = last_rd[inst];
      if (!e.err)
        for (int i = 0; i < 4; i++)
          if (b[i]) model[inst][a[9:2]][8*i +: 8] = d[8*i +: 8];
    end
    sb.push_back(e);
    sel = (inst == 1);
    req_d = 1'b1; we_d = w; addr_d = a; wdata_d = d; be_d = b;
    @(posedge clk);
    #1 req_d = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (obs_ack) seen = 1'b1;
    end
    e = sb.pop_front();
    chk("ack_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("err", 32'(obs_err), 32'(e.err));
    chk("rdata", obs_rdata, e.rdata);
    chk("busy_at_ack", 32'(obs_busy), 32'd1);
    @(negedge clk);
    chk("ack_pulse", 32'(obs_ack), 32'd0);
    chk("err_outside", 32'(obs_err), 32'd0);
    chk("busy_after", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    int acks;
    repeat (2) @(negedge clk);
    chk("rst_ack2", 32'(b2.ack), 32'd0);
    chk("rst_err2", 32'(b2.err), 32'd0);
    chk("rst_busy2", 32'(b2.busy), 32'd0);
    chk("rst_rdata2", b2.rdata, 32'd0);
    chk("rst_ack0", 32'(b0.ack), 32'd0);
    chk("rst_rdata0", b0.rdata, 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    do_txn(1, 1'b0, 32'h10, 32'h0, 4'b0000);
    do_txn(1, 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    do_txn(1, 1'b0, 32'h10, 32'h0, 4'b1111);
    do_txn(1, 1'b1, 32'h13, 32'h11111111, 4'b1111);
    do_txn(1, 1'b0, 32'h400, 32'h0, 4'b1111);
    do_txn(1, 1'b0, 32'h10, 32'h0, 4'b1111);
    do_txn(1, 1'b1, 32'h10, 32'h55555555, 4'b0000);
    do_txn(1, 1'b0, 32'h10, 32'h0, 4'b1111);
    chk("final_word", obs_rdata, 32'hDEADAAEF);

    do_txn(0, 1'b1, 32'h10, 32'hA5A55A5A, 4'b1111);
    sel = 1'b0;
    req_d = 1'b1; we_d = 1'b0; addr_d = 32'h10; be_d = 4'b1111;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_ack) acks++;
      chk("b2b_ack", 32'(obs_ack), 32'((i % 2) == 0));
      chk("b2b_busy", 32'(obs_busy), 32'((i % 2) == 0));
    end
    req_d = 1'b0;
    chk("b2b_ack_count", 32'(acks), 32'd3);
    chk("b2b_rdata", obs_rdata, 32'hA5A55A5A);
    @(negedge clk);
    chk("b2b_idle", 32'(obs_busy), 32'd0);

    do_txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111);
    sel = 1'b1;
    req_d = 1'b1; we_d = 1'b1; addr_d = 32'h20; wdata_d = 32'h12345678; be_d = 4'b1111;
    @(posedge clk);
    #1 req_d = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(b2.ack), 32'd0);
    chk("mid_rst_err", 32'(b2.err), 32'd0);
    chk("mid_rst_busy", 32'(b2.busy), 32'd0);
    chk("mid_rst_rdata", b2.rdata, 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (b2.ack) acks++;
    end
    chk("mid_rst_no_ack", 32'(acks), 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1, 1'b0, 32'h20, 32'h0, 4'b1111);
    chk("no_aborted_write", obs_rdata, 32'hCAFEF00D);
    do_txn(1, 1'b1, 32'h30, 32'h01020304, 4'b1111);
    do_txn(1, 1'b1, 32'h34, 32'hF0E0D0C0, 4'b1111);
    do_txn(1, 1'b0, 32'h30, 32'h0, 4'b1111);
    do_txn(1, 1'b0, 32'h34, 32'h0, 4'b1111);
    do_txn(1, 1'b0, 32'h31, 32'h0, 4'b1111);
`ifdef DMEM_STATS_EN
    chk("rd_count", 32'(rd2), 32'd3);
    chk("wr_count", 32'(wr2), 32'd2);
    chk("err_count", 32'(er2), 32'd1);
    chk("rd_count0", 32'(rd0), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
